// File: rtl/alu_issue_if.sv
// Request/response handshake bundle for alu_issue_stage.
// slave: the issue stage; master: the producer/consumer.
interface alu_issue_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [5:0]  REQ_OPRN;
  logic [31:0] REQ_OP1;
  logic [31:0] REQ_OP2;
  logic        REQ_FWD;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_ZERO;
  logic        RSP_ERR;

  modport slave (
    input  REQ_VALID, REQ_OPRN, REQ_OP1,
    input  REQ_OP2, REQ_FWD, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA,
    output RSP_ZERO, RSP_ERR
  );

  modport master (
    output REQ_VALID, REQ_OPRN, REQ_OP1,
    output REQ_OP2, REQ_FWD, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA,
    input  RSP_ZERO, RSP_ERR
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage feeding a combinational ALU: 2-entry FIFO,
// issue register, result register. ALU_ISSUE_FWD_EN adds OP1 forwarding.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  alu_issue_if.slave       bus,
  output logic [5:0]       ALU_OPRN,
  output logic [31:0]      ALU_OP1,
  output logic [31:0]      ALU_OP2,
  input  logic [31:0]      ALU_OUT,
  input  logic             ALU_ZERO,
  output logic [CNT_W-1:0] OP_COUNT,
  output logic             BUSY
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd;
`endif
  } entry_t;

  entry_t      mem [2];
  entry_t      in_e;
  entry_t      head;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        iss_v;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic        push;
  logic        pop;
  logic        res_free;
  logic        iss_free;
  logic        cap;
  logic        illegal;
  logic [31:0] op1_nxt;

  assign bus.REQ_READY = (count < FULL);
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_DATA  = rsp_data;
  assign bus.RSP_ZERO  = rsp_zero;
  assign bus.RSP_ERR   = rsp_err;

  assign push     = bus.REQ_VALID && bus.REQ_READY;
  assign res_free = !rsp_valid || bus.RSP_READY;
  assign iss_free = !iss_v || res_free;
  assign pop      = iss_free && (count != 2'd0);
  assign cap      = iss_v && res_free;
  assign illegal  = (ALU_OPRN == 6'd0) || (ALU_OPRN > 6'd9);
  assign head     = mem[rd_ptr];
  assign BUSY     = (count != 2'd0) || iss_v || rsp_valid;

  always_comb begin
    in_e      = '0;
    in_e.oprn = bus.REQ_OPRN;
    in_e.op1  = bus.REQ_OP1;
    in_e.op2  = bus.REQ_OP2;
`ifdef ALU_ISSUE_FWD_EN
    in_e.fwd  = bus.REQ_FWD;
`endif
  end

`ifdef ALU_ISSUE_FWD_EN
  logic [31:0] last_q;
  logic [31:0] fwd_val;

  // in-flight result wins over the stored one when both exist
  assign fwd_val = cap ? (illegal ? 32'd0 : ALU_OUT) : last_q;
  assign op1_nxt = head.fwd ? fwd_val : head.op1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last_q <= '0;
    else if (cap)
      last_q <= illegal ? 32'd0 : ALU_OUT;
  end
`else
  logic unused_fwd;

  assign unused_fwd = bus.REQ_FWD;
  assign op1_nxt    = head.op1;
`endif

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= in_e;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      iss_v    <= 1'b0;
      ALU_OPRN <= '0;
      ALU_OP1  <= '0;
      ALU_OP2  <= '0;
    end else if (pop) begin
      iss_v    <= 1'b1;
      ALU_OPRN <= head.oprn;
      ALU_OP1  <= op1_nxt;
      ALU_OP2  <= head.op2;
    end else if (iss_free) begin
      iss_v    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (cap) begin
      rsp_valid <= 1'b1;
      rsp_data  <= illegal ? 32'd0 : ALU_OUT;
      rsp_zero  <= illegal ? 1'b1 : ALU_ZERO;
      rsp_err   <= illegal;
    end else if (bus.RSP_READY) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      OP_COUNT <= '0;
    else if (rsp_valid && bus.RSP_READY)
      OP_COUNT <= OP_COUNT + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage with a behavioural ALU.
// Build with +define+ALU_ISSUE_FWD_EN to exercise forwarding.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  alu_oprn;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [15:0] op_count;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t        sb [$];
  int          rcyc [$];
  int          checks = 0;
  int          failures = 0;
  int          rsp_seen = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  alu_issue_if bus ();

  alu_issue_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .ALU_OPRN (alu_oprn),
    .ALU_OP1  (alu_op1),
    .ALU_OP2  (alu_op2),
    .ALU_OUT  (alu_out),
    .ALU_ZERO (alu_zero),
    .OP_COUNT (op_count),
    .BUSY     (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(
    input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd1:    return a + b;
      6'd2:    return a - b;
      6'd3:    return a * b;
      6'd4:    return a >> b;
      6'd5:    return a << b;
      6'd6:    return a & b;
      6'd7:    return a | b;
      6'd8:    return ~(a | b);
      6'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_out  = alu_f(alu_oprn, alu_op1, alu_op2);
    alu_zero = (alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST && bus.RSP_VALID && bus.RSP_READY) begin
      rsp_t e;
      rsp_seen++;
      rcyc.push_back(cyc);
      chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_data", 64'(bus.RSP_DATA), 64'(e.data));
        chk("rsp_zero", 64'(bus.RSP_ZERO), 64'(e.zero));
        chk("rsp_err", 64'(bus.RSP_ERR), 64'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fwd);
    logic [31:0] ea;
    logic [31:0] d;
    logic        legal;
    bit          done;
    done = 0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_OPRN  = op;
    bus.REQ_OP1   = a;
    bus.REQ_OP2   = b;
    bus.REQ_FWD   = fwd;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.REQ_READY) done = 1;
      step();
    end
    bus.REQ_VALID = 1'b0;
    chk("send_accept", 64'(done), 64'd1);
    if (done) begin
`ifdef ALU_ISSUE_FWD_EN
      ea = fwd ? last_exp : a;
`else
      ea = a;
`endif
      legal = (op >= 6'd1) && (op <= 6'd9);
      d = legal ? alu_f(op, ea, b) : 32'd0;
      last_exp = d;
      sb.push_back('{d, legal ? (d == 32'd0) : 1'b1, !legal});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  initial begin
    int n0;
    logic [5:0]  h_oprn;
    logic [31:0] h_op1;
    logic [31:0] h_op2;
    bus.REQ_VALID = 1'b0;
    bus.REQ_OPRN  = '0;
    bus.REQ_OP1   = '0;
    bus.REQ_OP2   = '0;
    bus.REQ_FWD   = 1'b0;
    bus.RSP_READY = 1'b0;
    #2;
    chk("rst_req_ready", 64'(bus.REQ_READY), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    step();
    step();
    RST = 1'b1;
    bus.RSP_READY = 1'b1;
    step();

    // add 5 + -5: latency of two edges after accept
    send(6'd1, 32'd5, 32'hFFFF_FFFB, 1'b0);
    chk("lat_k0_valid", 64'(bus.RSP_VALID), 64'd0);
    step();
    chk("lat_k1_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("lat_k1_oprn", 64'(alu_oprn), 64'd1);
    chk("lat_k1_op1", 64'(alu_op1), 64'd5);
    step();
    chk("lat_k2_valid", 64'(bus.RSP_VALID), 64'd1);
    step();
    chk("lat_op_count", 64'(op_count), 64'd1);
    chk("lat_busy", 64'(busy), 64'd0);

    // back-to-back stream
    n0 = rcyc.size();
    send(6'd2, 32'd10, 32'd4, 1'b0);
    send(6'd3, 32'd600203, 32'd1000, 1'b0);
    send(6'd5, 32'd20, 32'd3, 1'b0);
    send(6'd9, 32'd2, 32'd10, 1'b0);
    drain();
    chk("stream_count", 64'(rcyc.size() - n0), 64'd4);
    if (rcyc.size() == n0 + 4)
      chk("stream_back2back", 64'(rcyc[n0+3] - rcyc[n0]), 64'd3);

    // backpressure
    bus.RSP_READY = 1'b0;
    send(6'd2, 32'd100, 32'd1, 1'b0);
    send(6'd6, 32'h0000_FF0F, 32'h0000_0FF0, 1'b0);
    send(6'd7, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    send(6'd8, 32'd0, 32'd0, 1'b0);
    chk("bp_req_ready", 64'(bus.REQ_READY), 64'd0);
    chk("bp_rsp_valid", 64'(bus.RSP_VALID), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    h_oprn = alu_oprn;
    h_op1  = alu_op1;
    h_op2  = alu_op2;
    chk("bp_iss_oprn", 64'(h_oprn), 64'd6);
    chk("bp_iss_op1", 64'(h_op1), 64'h0000_FF0F);
    step();
    step();
    step();
    chk("bp_hold_oprn", 64'(alu_oprn), 64'(h_oprn));
    chk("bp_hold_op1", 64'(alu_op1), 64'(h_op1));
    chk("bp_hold_op2", 64'(alu_op2), 64'(h_op2));
    chk("bp_hold_ready", 64'(bus.REQ_READY), 64'd0);
    chk("bp_hold_data", 64'(bus.RSP_DATA), 64'd99);
    bus.RSP_READY = 1'b1;
    drain();
    chk("bp_op_count", 64'(op_count), 64'(rsp_seen));

    // illegal opcode between legal neighbours
    send(6'd1, 32'd7, 32'd8, 1'b0);
    send(6'd12, 32'd3, 32'd4, 1'b0);
    send(6'd2, 32'd9, 32'd2, 1'b0);
    drain();

`ifdef ALU_ISSUE_FWD_EN
    send(6'd1, 32'd3, 32'd4, 1'b0);
    send(6'd5, 32'd99, 32'd2, 1'b1);
    drain();
    send(6'd1, 32'd3, 32'd4, 1'b0);
    step();
    step();
    step();
    send(6'd5, 32'd99, 32'd2, 1'b1);
    drain();
`else
    send(6'd5, 32'd5, 32'd1, 1'b1);
    drain();
`endif
    chk("op_count_mid", 64'(op_count), 64'(rsp_seen));

    // reset with work in flight
    bus.RSP_READY = 1'b0;
    send(6'd1, 32'd1, 32'd2, 1'b0);
    send(6'd1, 32'd3, 32'd4, 1'b0);
    send(6'd1, 32'd5, 32'd6, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk("mrst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    chk("mrst_req_ready", 64'(bus.REQ_READY), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_op_count", 64'(op_count), 64'd0);
    chk("mrst_alu_oprn", 64'(alu_oprn), 64'd0);
    chk("mrst_alu_op1", 64'(alu_op1), 64'd0);
    chk("mrst_rsp_data", 64'(bus.RSP_DATA), 64'd0);
    sb.delete();
    last_exp = '0;
    rsp_seen = 0;
    step();
    step();
    RST = 1'b1;
    bus.RSP_READY = 1'b1;
    step();
    send(6'd1, 32'd1, 32'd1, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_rsp_count", 64'(rsp_seen), 64'd1);
    chk("post_rst_op_count", 64'(op_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
